// File: rtl/pc_pkg.sv
// pc_pkg: shared action encoding, RAS sizing helper and default vectors for pc_unit_ras.
package pc_pkg;
    typedef enum logic [1:0] {PC_SEQ, PC_JUMP, PC_CALL, PC_RET} pc_act_e;
    localparam logic [31:0] PC_RESET_VEC = 32'h0;
    localparam logic [31:0] PC_TRAP_VEC = 32'h0;
    function automatic int ras_ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with push, pop and swap.
// A push when full overwrites the oldest entry; count saturates at DEPTH.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         swap,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PW = ras_ptr_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] ptr, ptr_nxt;
    // ptr indexes the current top entry; DEPTH is a power of two so it wraps naturally
    assign ptr_nxt = ptr + 1'b1;
    assign top = mem[ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr_nxt;
            count <= count == ($clog2(DEPTH+1))'(DEPTH) ? count : count + 1'b1;
        end else if (pop) begin
            ptr <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr_nxt] <= din;
        else if (swap)
            mem[ptr] <= din;
    end
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch-stage PC with first-fetch hold, jump/call/return and a circular RAS.
// Define PC_WRAP_TRAP_EN to redirect a sequential wrap to TRAP_VEC.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter int unsigned      RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(PC_TRAP_VEC)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               we,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [WIDTH-1:0]                   target,
    output logic [WIDTH-1:0]                   out,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_underflow,
    output logic                               wrap
);
    logic init, go, empty, carry, push, pop, swap, uf_n, wrap_n;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] seq_pc, next_pc, top;
    pc_act_e act;
`ifndef PC_WRAP_TRAP_EN
    logic unused_trap;
    assign unused_trap = ^TRAP_VEC;
`endif
    always_comb begin
        sum = {1'b0, out} + (WIDTH+1)'(STEP);
        carry = sum[WIDTH];
`ifdef PC_WRAP_TRAP_EN
        seq_pc = carry ? TRAP_VEC : sum[WIDTH-1:0];
`else
        seq_pc = sum[WIDTH-1:0];
`endif
        act = ret ? PC_RET : call ? PC_CALL : jump ? PC_JUMP : PC_SEQ;
        go = we && init;
        empty = ras_count == '0;
        push = go && act == PC_CALL;
        pop = go && ret && !empty && !call;
        swap = go && ret && !empty && call;
        uf_n = go && ret && empty;
        wrap_n = go && act == PC_SEQ && carry;
        // a return on an empty stack falls through to out+STEP without trapping
        next_pc = act == PC_RET ? (empty ? sum[WIDTH-1:0] : top) :
                  act == PC_SEQ ? seq_pc : target;
    end
    ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .swap(swap),
        .din(sum[WIDTH-1:0]),
        .top(top),
        .count(ras_count)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= RESET_VEC;
            init <= 1'b0;
            ras_underflow <= 1'b0;
            wrap <= 1'b0;
        end else begin
            ras_underflow <= uf_n;
            wrap <= wrap_n;
            if (we && !init)
                init <= 1'b1;
            else if (go)
                out <= next_pc;
        end
    end
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed plus randomized checks of pc_unit_ras against a queue-based model.
module tb_pc_unit_ras;
    localparam int W = 8;
    localparam int MASK = 255;
    localparam int TRAP = 8;
    logic clk = 1'b0, reset = 1'b1, we = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [W-1:0] target = '0, out;
    logic [2:0] ras_count;
    logic ras_underflow, wrap;
    int errors = 0, checks = 0;
    int m_pc = 0, m_init = 0, m_uf = 0, m_wr = 0;
    int q[$];

    pc_unit_ras #(.WIDTH(W), .STEP(1), .RESET_VEC(8'd0), .RAS_DEPTH(4), .TRAP_VEC(8'd8)) dut (
        .clk(clk), .reset(reset), .we(we), .jump(jump), .call(call), .ret(ret),
        .target(target), .out(out), .ras_count(ras_count),
        .ras_underflow(ras_underflow), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"}, int'(out), m_pc);
        chk({tag, ".count"}, int'(ras_count), q.size());
        chk({tag, ".uf"}, int'(ras_underflow), m_uf);
        chk({tag, ".wrap"}, int'(wrap), m_wr);
    endtask

    task automatic model_reset();
        m_pc = 0; m_init = 0; m_uf = 0; m_wr = 0;
        q.delete();
    endtask

    task automatic model_step(input bit w, input bit j, input bit c, input bit r, input int t);
        int nxt;
        m_uf = 0; m_wr = 0;
        if (!w) return;
        if (!m_init) begin
            m_init = 1;
            return;
        end
        if (r) begin
            if (q.size() > 0) begin
                nxt = q[$];
                if (c) q[$] = (m_pc + 1) & MASK;
                else void'(q.pop_back());
                m_pc = nxt;
            end else begin
                m_pc = (m_pc + 1) & MASK;
                m_uf = 1;
            end
        end else if (c) begin
            if (q.size() == 4) void'(q.pop_front());
            q.push_back((m_pc + 1) & MASK);
            m_pc = t;
        end else if (j) begin
            m_pc = t;
        end else if (m_pc + 1 > MASK) begin
            m_wr = 1;
`ifdef PC_WRAP_TRAP_EN
            m_pc = TRAP;
`else
            m_pc = 0;
`endif
        end else begin
            m_pc = m_pc + 1;
        end
    endtask

    task automatic cyc(input bit w, input bit j, input bit c, input bit r, input int t, input string tag);
        we = w; jump = j; call = c; ret = r; target = W'(t);
        @(posedge clk);
        model_step(w, j, c, r, t);
        #2;
        check_all(tag);
    endtask

    task automatic areset(input string tag);
        #1 reset = 1'b1;
        we = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 check_all("reset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, "boot");
            chk("boot.lit", int'(out), i == 0 ? 0 : i);
        end
        areset("midreset");
        cyc(1, 0, 0, 0, 0, "ff");
        cyc(1, 1, 0, 0, 10, "j10");
        cyc(1, 0, 1, 0, 100, "call100");
        chk("call100.lit", int'(out), 100);
        cyc(1, 0, 0, 0, 0, "s1");
        cyc(1, 0, 0, 0, 0, "s2");
        cyc(1, 0, 0, 1, 0, "ret11");
        chk("ret11.lit", int'(out), 11);
        cyc(1, 1, 0, 0, 20, "j20");
        for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0, 30 + 10 * k, "call5");
        chk("full.count", int'(ras_count), 4);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 1, 0, "ret4");
            chk("ret4.lit", int'(out), 61 - 10 * k);
        end
        cyc(1, 0, 0, 1, 0, "uflow");
        chk("uflow.lit", int'(ras_underflow), 1);
        cyc(1, 0, 0, 0, 0, "uflow_end");
        cyc(1, 1, 0, 0, 199, "j199");
        cyc(1, 0, 1, 0, 15, "call15");
        cyc(1, 0, 1, 1, 77, "swap");
        chk("swap.lit", int'(out), 200);
        cyc(1, 0, 0, 1, 0, "ret_swap");
        chk("ret_swap.lit", int'(out), 16);
        cyc(0, 1, 0, 0, 77, "hold");
        chk("hold.lit", int'(out), 16);
        cyc(1, 1, 0, 0, 255, "j255");
        cyc(1, 0, 0, 0, 0, "wrap");
`ifdef PC_WRAP_TRAP_EN
        chk("wrap.lit", int'(out), TRAP);
`else
        chk("wrap.lit", int'(out), 0);
`endif
        chk("wrap.pulse", int'(wrap), 1);
        cyc(1, 0, 0, 0, 0, "wrap_end");
        for (int n = 0; n < 600; n++) begin
            int t;
            if ($urandom_range(0, 63) == 0) areset("rnd_reset");
            t = $urandom_range(0, 3) == 0 ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 255));
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, t, "rnd");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
